// File: rtl/command_frame_initiator_if.sv
// Host byte link, response stream and command bus of the frame initiator.
// master = initiator side, slave = host/consumer side.
interface command_frame_initiator_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            rx_data_i;
  logic                  rx_valid_i;
  logic                  rx_ready_o;
  logic [7:0]            tx_data_o;
  logic                  tx_valid_o;
  logic                  tx_ready_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_o;
  logic [DATA_WIDTH-1:0] cmd_data_o;
  logic                  cmd_valid_o;
  logic                  err_chk_o;
  logic                  err_timeout_o;
  logic [15:0]           frame_count_o;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o, cmd_addr_o, cmd_data_o,
           cmd_valid_o, err_chk_o, err_timeout_o, frame_count_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, cmd_addr_o, cmd_data_o,
           cmd_valid_o, err_chk_o, err_timeout_o, frame_count_o
  );
endinterface

// File: rtl/command_frame_initiator.sv
// Parses SYNC/ADDR(2)/DATA(4)/CHK byte frames into one-cycle command writes
// and answers each complete frame with an ACK or NAK byte.
module command_frame_initiator #(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  command_frame_initiator_if.master bus
);
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_ISSUE = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_idx;
  logic [15:0]           r_addr_asm;
  logic [31:0]           r_data_asm;
  logic [7:0]            r_sum;
  logic [TW-1:0]         r_to_cnt;
  logic                  r_good;
  logic                  r_rx_ready, r_tx_valid, r_cmd_valid, r_err_chk, r_err_to;
  logic [7:0]            r_tx_data;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [DATA_WIDTH-1:0] r_cmd_data;
  logic [15:0]           r_frame_count;
  logic                  w_fire, w_in_frame, w_timeout, w_match;
  logic                  w_rx_ready_nx, w_tx_valid_nx, w_cmd_valid_nx, w_err_chk_nx, w_err_to_nx;
  logic [7:0]            w_tx_data_nx;

  assign w_fire     = bus.rx_valid_i & r_rx_ready;
  assign w_in_frame = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHECK);
  // An accepted byte on the last counted cycle suppresses the timeout.
  assign w_timeout  = w_in_frame & ~w_fire & (r_to_cnt == TO_LAST);
  assign w_match    = (r_sum == bus.rx_data_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fire && (bus.rx_data_i == SYNC_BYTE)) w_next = S_HDR;
               else w_next = S_IDLE;
      S_HDR:   if (w_fire && (r_idx == 2'd1)) w_next = S_DATA;
               else if (w_timeout) w_next = S_IDLE;
               else w_next = S_HDR;
      S_DATA:  if (w_fire && (r_idx == 2'd3)) w_next = S_CHECK;
               else if (w_timeout) w_next = S_IDLE;
               else w_next = S_DATA;
      S_CHECK: if (w_fire) w_next = S_ISSUE;
               else if (w_timeout) w_next = S_IDLE;
               else w_next = S_CHECK;
      S_ISSUE: w_next = S_RESP;
      S_RESP:  if (r_tx_valid && bus.tx_ready_i) w_next = S_IDLE;
               else w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_valid_nx = 1'b0;
    w_err_chk_nx   = 1'b0;
    w_err_to_nx    = w_timeout;
    w_tx_data_nx   = r_tx_data;
    case (w_next)
      S_IDLE, S_HDR, S_DATA, S_CHECK: w_rx_ready_nx = 1'b1;
      default:                        w_rx_ready_nx = 1'b0;
    endcase
    if (r_state == S_CHECK && w_fire) begin
      w_cmd_valid_nx = w_match;
      w_err_chk_nx   = ~w_match;
    end else begin
      w_cmd_valid_nx = 1'b0;
      w_err_chk_nx   = 1'b0;
    end
    if (r_state == S_ISSUE) begin
      w_tx_valid_nx = 1'b1;
      w_tx_data_nx  = r_good ? ACK_BYTE : NAK_BYTE;
    end else if (r_state == S_RESP && bus.tx_ready_i) begin
      w_tx_valid_nx = 1'b0;
    end else begin
      w_tx_valid_nx = (r_state == S_RESP) ? r_tx_valid : 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_idx      <= 2'd0;
      r_addr_asm <= 16'd0;
      r_data_asm <= 32'd0;
      r_sum      <= 8'd0;
      r_to_cnt   <= '0;
      r_good     <= 1'b0;
    end else begin
      if (w_in_frame && !w_fire && !w_timeout) r_to_cnt <= r_to_cnt + TO_ONE;
      else                                     r_to_cnt <= '0;
      if (r_state == S_IDLE && w_fire) begin
        r_idx <= 2'd0;
        r_sum <= 8'd0;
      end else if (r_state == S_HDR && w_fire) begin
        r_addr_asm <= {r_addr_asm[7:0], bus.rx_data_i};
        r_sum      <= r_sum + bus.rx_data_i;
        r_idx      <= (r_idx == 2'd1) ? 2'd0 : r_idx + 2'd1;
      end else if (r_state == S_DATA && w_fire) begin
        r_data_asm <= {r_data_asm[23:0], bus.rx_data_i};
        r_sum      <= r_sum + bus.rx_data_i;
        r_idx      <= r_idx + 2'd1;
      end else if (r_state == S_CHECK && w_fire) begin
        r_good <= w_match;
      end
    end
  end

  // Command outputs only move on a validated frame; otherwise they hold.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rx_ready    <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= 8'd0;
      r_cmd_valid   <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_data    <= '0;
      r_err_chk     <= 1'b0;
      r_err_to      <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_rx_ready  <= w_rx_ready_nx;
      r_tx_valid  <= w_tx_valid_nx;
      r_tx_data   <= w_tx_data_nx;
      r_cmd_valid <= w_cmd_valid_nx;
      r_err_chk   <= w_err_chk_nx;
      r_err_to    <= w_err_to_nx;
      if (w_cmd_valid_nx) begin
        r_cmd_addr    <= r_addr_asm[ADDR_WIDTH-1:0];
        r_cmd_data    <= r_data_asm[DATA_WIDTH-1:0];
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign bus.rx_ready_o    = r_rx_ready;
  assign bus.tx_valid_o    = r_tx_valid;
  assign bus.tx_data_o     = r_tx_data;
  assign bus.cmd_valid_o   = r_cmd_valid;
  assign bus.cmd_addr_o    = r_cmd_addr;
  assign bus.cmd_data_o    = r_cmd_data;
  assign bus.err_chk_o     = r_err_chk;
  assign bus.err_timeout_o = r_err_to;
  assign bus.frame_count_o = r_frame_count;
endmodule

// File: tb/tb_command_frame_initiator.sv
// Scoreboard bench for command_frame_initiator: stimulus pushes expectations,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_command_frame_initiator;
  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;

  command_frame_initiator_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  command_frame_initiator #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [15:0] fc;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [7:0]  exp_tx[$];
  int          cmd_cyc_q[$];
  int          exp_chk = 0;
  int          exp_to  = 0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          chk_cyc = -1;
  int          to_cyc = -1;
  int          tx_rise_cyc = -1;
  int          n = 0;
  logic [15:0] exp_fc = 16'd0;
  logic        prev_tx_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Monitor: pops expectations whenever the DUT emits something.
  initial forever begin
    @(negedge clk_i);
    if (rst_n_i) begin
      if (bus.cmd_valid_o) begin
        cmd_t e;
        check("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
        check("cmd_err_exclusive", 64'({bus.err_chk_o, bus.err_timeout_o}), 64'd0);
        cmd_cyc_q.push_back(cyc);
        if (exp_cmd.size() != 0) begin
          e = exp_cmd.pop_front();
          check("cmd_addr", 64'(bus.cmd_addr_o), 64'(e.addr));
          check("cmd_data", 64'(bus.cmd_data_o), 64'(e.data));
          check("frame_count", 64'(bus.frame_count_o), 64'(e.fc));
        end
      end
      if (bus.err_chk_o) begin
        check("err_chk_expected", 64'(exp_chk > 0), 64'd1);
        if (exp_chk > 0) exp_chk--;
        chk_cyc = cyc;
      end
      if (bus.err_timeout_o) begin
        check("err_timeout_expected", 64'(exp_to > 0), 64'd1);
        if (exp_to > 0) exp_to--;
        to_cyc = cyc;
      end
      if (bus.tx_valid_o && !prev_tx_valid) tx_rise_cyc = cyc;
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        check("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
        if (exp_tx.size() != 0) check("tx_data", 64'(bus.tx_data_o), 64'(exp_tx.pop_front()));
      end
      prev_tx_valid = bus.tx_valid_o;
    end else begin
      prev_tx_valid = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk_i);
      if (bus.rx_ready_o) begin
        last_acc = cyc;
        done = 1'b1;
      end
    end
    check("rx_accept", 64'(done), 64'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [31:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(c);
  endtask

  task automatic expect_good(input logic [15:0] a, input logic [31:0] d);
    cmd_t e;
    exp_fc = exp_fc + 16'd1;
    e.addr = a;
    e.data = d;
    e.fc   = exp_fc;
    exp_cmd.push_back(e);
    exp_tx.push_back(8'h06);
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      empty = (exp_cmd.size() == 0) && (exp_tx.size() == 0) && (exp_chk == 0) && (exp_to == 0);
      if (empty) break;
    end
    check("drain", 64'(empty), 64'd1);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 64'(bus.rx_ready_o), 64'd0);
    check({tag, "_tx_valid"}, 64'(bus.tx_valid_o), 64'd0);
    check({tag, "_tx_data"}, 64'(bus.tx_data_o), 64'd0);
    check({tag, "_cmd_valid"}, 64'(bus.cmd_valid_o), 64'd0);
    check({tag, "_cmd_addr"}, 64'(bus.cmd_addr_o), 64'd0);
    check({tag, "_cmd_data"}, 64'(bus.cmd_data_o), 64'd0);
    check({tag, "_errs"}, 64'({bus.err_chk_o, bus.err_timeout_o}), 64'd0);
    check({tag, "_frame_count"}, 64'(bus.frame_count_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rx_ready_after_reset", 64'(bus.rx_ready_o), 64'd1);

    // 1: good frame
    expect_good(16'h0060, 32'h0000_012C);
    send_frame(16'h0060, 32'h0000_012C, 8'h8D);
    n = last_acc;
    bus.rx_valid_i = 1'b0;
    drain();
    check("t1_cmd_latency", 64'(cmd_cyc_q[$] - n), 64'd1);
    check("t1_tx_latency", 64'(tx_rise_cyc - n), 64'd2);
    check("t1_frame_count", 64'(bus.frame_count_o), 64'd1);

    // 2: bad checksum
    exp_tx.push_back(8'h15);
    exp_chk++;
    send_frame(16'h0060, 32'h0000_012C, 8'h8E);
    n = last_acc;
    bus.rx_valid_i = 1'b0;
    drain();
    check("t2_chk_latency", 64'(chk_cyc - n), 64'd1);
    check("t2_tx_latency", 64'(tx_rise_cyc - n), 64'd2);
    check("t2_frame_count", 64'(bus.frame_count_o), 64'd1);
    check("t2_cmd_held", 64'(bus.cmd_addr_o), 64'h0060);

    // 3: leading garbage
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    expect_good(16'h0060, 32'h0000_012C);
    send_frame(16'h0060, 32'h0000_012C, 8'h8D);
    bus.rx_valid_i = 1'b0;
    drain();

    // 4: intra-frame timeout, then recovery
    exp_to++;
    to_cyc = -1;
    send_byte(8'hA5);
    send_byte(8'h00);
    n = last_acc;
    bus.rx_valid_i = 1'b0;
    drain();
    check("t4_timeout_latency", 64'(to_cyc - n), 64'd17);
    expect_good(16'h0060, 32'h0000_012C);
    send_frame(16'h0060, 32'h0000_012C, 8'h8D);
    bus.rx_valid_i = 1'b0;
    drain();

    // 5: response backpressure
    bus.tx_ready_i = 1'b0;
    expect_good(16'h0060, 32'h0000_012C);
    send_frame(16'h0060, 32'h0000_012C, 8'h8D);
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("t5_tx_valid_held", 64'(bus.tx_valid_o), 64'd1);
      check("t5_tx_data_held", 64'(bus.tx_data_o), 64'h06);
      check("t5_rx_blocked", 64'(bus.rx_ready_o), 64'd0);
    end
    @(posedge clk_i);
    #1 bus.tx_ready_i = 1'b1;
    drain();
    bus.rx_valid_i = 1'b0;
    check("t5_frame_count", 64'(bus.frame_count_o), 64'd4);

    // 6: reset mid-frame, then two back-to-back frames
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h60);
    send_byte(8'h00);
    rst_n_i = 1'b0;
    bus.rx_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("midreset");
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    exp_fc = 16'd0;
    @(posedge clk_i);
    #1;
    check("t6_rx_ready", 64'(bus.rx_ready_o), 64'd1);
    cmd_cyc_q.delete();
    expect_good(16'h00A5, 32'h0000_0001);
    expect_good(16'h1234, 32'hDEAD_BEEF);
    send_frame(16'h00A5, 32'h0000_0001, 8'hA6);
    send_frame(16'h1234, 32'hDEAD_BEEF, 8'h7E);
    bus.rx_valid_i = 1'b0;
    drain();
    check("t6_cmd_count", 64'(cmd_cyc_q.size()), 64'd2);
    check("t6_cmd_spacing", 64'(cmd_cyc_q[1] - cmd_cyc_q[0]), 64'd10);
    check("t6_frame_count", 64'(bus.frame_count_o), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
